// File: rtl/famiclone_detect_pkg.sv
// famiclone_detect_pkg
//   Shared definitions for the power-on famiclone detector:
//   - state_t       : FSM state encoding (HOLD=0, OBSERVE=1, DECIDED=2; 3 is illegal)
//   - FORCE_*       : firmware override codes carried on force_mode
//   - ppu_vec_t     : one captured PPU pin vector {rd, a13, not_a13}
//   - fits_width()  : parameter range check used at elaboration
package famiclone_detect_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_OBSERVE  = 2'd1,
        ST_DECIDED  = 2'd2
    } state_t;

    localparam logic [1:0] FORCE_AUTO    = 2'b00;
    localparam logic [1:0] FORCE_CLASSIC = 2'b01;
    localparam logic [1:0] FORCE_NEW     = 2'b10;

    typedef struct packed {
        logic rd;
        logic a13;
        logic not_a13;
    } ppu_vec_t;

    // Synchroniser contents after reset: bus idle (/RD high).
    localparam ppu_vec_t PPU_IDLE = '{rd: 1'b1, a13: 1'b0, not_a13: 1'b0};

    // True when a non-negative value can be held in an unsigned field of the given width.
    function automatic bit fits_width(input int value, input int width);
        if (value < 0) begin
            return 1'b0;
        end
        if (width >= 31) begin
            return 1'b1;
        end
        return value < (1 << width);
    endfunction

endpackage

// File: rtl/ppu_sample_sync.sv
// ppu_sample_sync
//   Captures the PPU pins as one vector on every clk rise (stage s1), copies it
//   to stage s2 the next cycle, and qualifies a sample from the two stages.
//   Ports:
//     clk, rst_n        : M2 clock, async active-low reset
//     rd, a13, not_a13  : raw PPU /RD, A13 and cartridge-edge /A13 (async to clk)
//     sample_valid      : /RD low in both stages and A13 identical in both
//     sample_a13        : A13 of the qualified sample (from s2)
//     sample_mismatch   : valid sample where /A13 is not the inverse of A13
module ppu_sample_sync
    import famiclone_detect_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rd,
    input  logic a13,
    input  logic not_a13,
    output logic sample_valid,
    output logic sample_a13,
    output logic sample_mismatch
);

    ppu_vec_t s1;
    ppu_vec_t s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= PPU_IDLE;
            s2 <= PPU_IDLE;
        end else begin
            s1 <= '{rd: rd, a13: a13, not_a13: not_a13};
            s2 <= s1;
        end
    end

    // Requiring two agreeing captures filters out reads whose edges skew
    // against M2; a read must span two rising edges to count once.
    always_comb begin
        sample_valid    = !s1.rd && !s2.rd && (s1.a13 == s2.a13);
        sample_a13      = s2.a13;
        sample_mismatch = sample_valid && (s2.a13 == s2.not_a13);
    end

endmodule

// File: rtl/famiclone_detect.sv
// famiclone_detect
//   Power-on famiclone ("new Dendy") detector. Holds CIRAM /CE and /A13 low for
//   INIT_CYCLES after reset, then watches PPU reads and classifies the console
//   by whether /A13 on the cartridge edge tracks ~A13.
//   Ports:
//     m2            : CPU M2, the only clock (rising edge)
//     rst_n         : async active-low reset
//     ppu_rd_in     : PPU /RD (async to m2)
//     ppu_a13_in    : PPU A13
//     ppu_not_a13   : PPU /A13 as seen on the cartridge edge
//     rescan        : one-cycle request to re-run detection
//     force_mode    : 00 auto, 01 classic, 10 new famiclone, 11 auto
//     hold_low      : 1 while in HOLD (top level grounds CIRAM /CE and /A13)
//     new_dendy     : classification after the firmware override
//     detect_done   : verdict valid
//     timed_out     : last verdict came from the timeout
//     state_dbg     : current FSM state encoding
//
//   rescan protocol: rescan is sampled on every m2 rise and has no ready/ack.
//   It is acted on only while DECIDED; in HOLD or OBSERVE it is dropped. The
//   requester sees acceptance as detect_done falling and state_dbg becoming 1.
module famiclone_detect
    import famiclone_detect_pkg::*;
#(
    parameter int INIT_WIDTH         = 4,
    parameter int INIT_CYCLES        = 15,
    parameter int CNT_WIDTH          = 3,
    parameter int SAMPLES_LO         = 3,
    parameter int SAMPLES_HI         = 3,
    parameter int MISMATCH_THRESHOLD = 1,
    parameter int TO_WIDTH           = 16,
    parameter int TIMEOUT_CYCLES     = 65535
) (
    input  logic       m2,
    input  logic       rst_n,
    input  logic       ppu_rd_in,
    input  logic       ppu_a13_in,
    input  logic       ppu_not_a13,
    input  logic       rescan,
    input  logic [1:0] force_mode,
    output logic       hold_low,
    output logic       new_dendy,
    output logic       detect_done,
    output logic       timed_out,
    output logic [1:0] state_dbg
);

    localparam bit CFG_OK =
        (INIT_CYCLES >= 1) && fits_width(INIT_CYCLES - 1, INIT_WIDTH) &&
        fits_width(SAMPLES_LO, CNT_WIDTH) && fits_width(SAMPLES_HI, CNT_WIDTH) &&
        (MISMATCH_THRESHOLD >= 1) && fits_width(MISMATCH_THRESHOLD, CNT_WIDTH) &&
        (TIMEOUT_CYCLES >= 1) && fits_width(TIMEOUT_CYCLES - 1, TO_WIDTH);

    if (!CFG_OK) begin : g_bad_cfg
        $error("famiclone_detect: parameter does not fit its counter width");
    end

    localparam logic [INIT_WIDTH-1:0] INIT_LAST = INIT_WIDTH'(INIT_CYCLES - 1);
    localparam logic [INIT_WIDTH-1:0] INIT_ONE  = INIT_WIDTH'(1);
    localparam logic [TO_WIDTH-1:0]   TO_LAST   = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_WIDTH-1:0]   TO_ONE    = TO_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  LO_FULL   = CNT_WIDTH'(SAMPLES_LO);
    localparam logic [CNT_WIDTH-1:0]  HI_FULL   = CNT_WIDTH'(SAMPLES_HI);
    localparam logic [CNT_WIDTH-1:0]  MIS_THR   = CNT_WIDTH'(MISMATCH_THRESHOLD);
    localparam logic [CNT_WIDTH-1:0]  MIS_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    state_t                state;
    logic [INIT_WIDTH-1:0] init_cnt;
    logic [TO_WIDTH-1:0]   to_cnt;
    logic [CNT_WIDTH-1:0]  lo_cnt;
    logic [CNT_WIDTH-1:0]  hi_cnt;
    logic [CNT_WIDTH-1:0]  mis_cnt;
    logic                  detected;
    logic                  hold_low_q;
    logic                  done_q;
    logic                  timed_out_q;

    logic                  sample_valid;
    logic                  sample_a13;
    logic                  sample_mismatch;

    ppu_sample_sync u_sync (
        .clk             (m2),
        .rst_n           (rst_n),
        .rd              (ppu_rd_in),
        .a13             (ppu_a13_in),
        .not_a13         (ppu_not_a13),
        .sample_valid    (sample_valid),
        .sample_a13      (sample_a13),
        .sample_mismatch (sample_mismatch)
    );

    // Next-count arithmetic for OBSERVE.
    logic [CNT_WIDTH-1:0] lo_next;
    logic [CNT_WIDTH-1:0] hi_next;
    logic [CNT_WIDTH-1:0] mis_next;
    logic                 counts_full;
    logic                 mis_counted;
    logic                 mis_hit;
    logic                 complete;
    logic                 timeout_hit;

    always_comb begin
        lo_next     = lo_cnt;
        hi_next     = hi_cnt;
        mis_next    = mis_cnt;
        counts_full = (lo_cnt == LO_FULL) && (hi_cnt == HI_FULL);
        // A mismatch on the sample that completes the counts still counts:
        // the check uses the counts from before this sample's update.
        mis_counted = sample_mismatch && !counts_full;

        if (sample_valid && !sample_a13 && (lo_cnt < LO_FULL)) begin
            lo_next = lo_cnt + CNT_ONE;
        end
        if (sample_valid && sample_a13 && (hi_cnt < HI_FULL)) begin
            hi_next = hi_cnt + CNT_ONE;
        end
        if (mis_counted && (mis_cnt != MIS_MAX)) begin
            mis_next = mis_cnt + CNT_ONE;
        end

        mis_hit     = mis_counted && (mis_next >= MIS_THR);
        complete    = (lo_next == LO_FULL) && (hi_next == HI_FULL);
        timeout_hit = (to_cnt == TO_LAST);
    end

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_HOLD;
            init_cnt    <= '0;
            to_cnt      <= '0;
            lo_cnt      <= '0;
            hi_cnt      <= '0;
            mis_cnt     <= '0;
            detected    <= 1'b0;
            hold_low_q  <= 1'b1;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (init_cnt == INIT_LAST) begin
                        state      <= ST_OBSERVE;
                        init_cnt   <= '0;
                        hold_low_q <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + INIT_ONE;
                    end
                end

                ST_OBSERVE: begin
                    to_cnt  <= to_cnt + TO_ONE;
                    lo_cnt  <= lo_next;
                    hi_cnt  <= hi_next;
                    mis_cnt <= mis_next;
                    if (mis_hit) begin
                        state    <= ST_DECIDED;
                        detected <= 1'b1;
                        done_q   <= 1'b1;
                    end else if (complete) begin
                        state    <= ST_DECIDED;
                        detected <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (timeout_hit) begin
                        state       <= ST_DECIDED;
                        detected    <= 1'b0;
                        done_q      <= 1'b1;
                        timed_out_q <= 1'b1;
                    end
                end

                ST_DECIDED: begin
                    // The previous verdict stays on new_dendy until the
                    // rescan produces a new one.
                    if (rescan) begin
                        state       <= ST_OBSERVE;
                        to_cnt      <= '0;
                        lo_cnt      <= '0;
                        hi_cnt      <= '0;
                        mis_cnt     <= '0;
                        done_q      <= 1'b0;
                        timed_out_q <= 1'b0;
                    end
                end

                default: begin
                    // Encoding 3 is unreachable; recover as from reset.
                    state       <= ST_HOLD;
                    init_cnt    <= '0;
                    to_cnt      <= '0;
                    lo_cnt      <= '0;
                    hi_cnt      <= '0;
                    mis_cnt     <= '0;
                    detected    <= 1'b0;
                    hold_low_q  <= 1'b1;
                    done_q      <= 1'b0;
                    timed_out_q <= 1'b0;
                end
            endcase
        end
    end

    // The override is combinational so firmware can pin the mode even while
    // the power-on hold or observation is still running.
    always_comb begin
        case (force_mode)
            FORCE_CLASSIC: new_dendy = 1'b0;
            FORCE_NEW:     new_dendy = 1'b1;
            default:       new_dendy = detected;
        endcase
    end

    assign hold_low    = hold_low_q;
    assign detect_done = done_q;
    assign timed_out   = timed_out_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_famiclone_detect.sv
// tb_famiclone_detect
//   Drives two detector instances (mismatch threshold 1 and 2, timeout 100)
//   from shared pins and compares every output against a behavioural model
//   after each m2 rise, plus directed timing checks.
module tb_famiclone_detect;

    localparam int INIT_CYCLES = 15;
    localparam int SAMPLES     = 3;
    localparam int TIMEOUT     = 100;

    // ---------------- clock / reset / pins ----------------
    logic       m2 = 1'b0;
    logic       rst_n;
    logic       ppu_rd_in;
    logic       ppu_a13_in;
    logic       ppu_not_a13;
    logic       rescan;
    logic [1:0] force_mode;

    logic       hl_a, nd_a, dd_a, to_a;
    logic [1:0] sd_a;
    logic       hl_b, nd_b, dd_b, to_b;
    logic [1:0] sd_b;

    always #10 m2 = ~m2;

    famiclone_detect #(
        .INIT_WIDTH(4), .INIT_CYCLES(INIT_CYCLES), .CNT_WIDTH(3),
        .SAMPLES_LO(SAMPLES), .SAMPLES_HI(SAMPLES), .MISMATCH_THRESHOLD(1),
        .TO_WIDTH(16), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut_a (
        .m2(m2), .rst_n(rst_n), .ppu_rd_in(ppu_rd_in), .ppu_a13_in(ppu_a13_in),
        .ppu_not_a13(ppu_not_a13), .rescan(rescan), .force_mode(force_mode),
        .hold_low(hl_a), .new_dendy(nd_a), .detect_done(dd_a),
        .timed_out(to_a), .state_dbg(sd_a)
    );

    famiclone_detect #(
        .INIT_WIDTH(4), .INIT_CYCLES(INIT_CYCLES), .CNT_WIDTH(3),
        .SAMPLES_LO(SAMPLES), .SAMPLES_HI(SAMPLES), .MISMATCH_THRESHOLD(2),
        .TO_WIDTH(16), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut_b (
        .m2(m2), .rst_n(rst_n), .ppu_rd_in(ppu_rd_in), .ppu_a13_in(ppu_a13_in),
        .ppu_not_a13(ppu_not_a13), .rescan(rescan), .force_mode(force_mode),
        .hold_low(hl_b), .new_dendy(nd_b), .detect_done(dd_b),
        .timed_out(to_b), .state_dbg(sd_b)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = power-on hold, 1 = observing, 2 = verdict held
    int         m_phase [2];
    int         m_hold_n[2];
    int         m_obs_n [2];
    int         m_lo    [2];
    int         m_hi    [2];
    int         m_mis   [2];
    bit         m_det   [2];
    bit         m_tmo   [2];
    logic [2:0] cap_q[$];   // pin vectors {rd,a13,not_a13} seen at each m2 rise

    function automatic int thr_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_hold_n[i] = 0; m_obs_n[i] = 0;
            m_lo[i] = 0; m_hi[i] = 0; m_mis[i] = 0;
            m_det[i] = 1'b0; m_tmo[i] = 1'b0;
        end
        cap_q.delete();
        cap_q.push_back(3'b100);
        cap_q.push_back(3'b100);
    endtask

    // One m2 rise: the decision uses the reads seen on the two previous rises.
    task automatic model_edge();
        logic [2:0] newer, older;
        bit valid, mism, a13s, full_before;
        newer = cap_q[cap_q.size()-1];
        older = cap_q[cap_q.size()-2];
        valid = !newer[2] && !older[2] && (newer[1] == older[1]);
        a13s  = older[1];
        mism  = valid && (older[1] == older[0]);
        for (int i = 0; i < 2; i++) begin
            case (m_phase[i])
                0: begin
                    m_hold_n[i]++;
                    if (m_hold_n[i] == INIT_CYCLES) m_phase[i] = 1;
                end
                1: begin
                    full_before = (m_lo[i] == SAMPLES) && (m_hi[i] == SAMPLES);
                    m_obs_n[i]++;
                    if (valid && !a13s && m_lo[i] < SAMPLES) m_lo[i]++;
                    if (valid && a13s && m_hi[i] < SAMPLES) m_hi[i]++;
                    if (mism && !full_before && m_mis[i] < 7) m_mis[i]++;
                    if (mism && !full_before && m_mis[i] >= thr_of(i)) begin
                        m_phase[i] = 2; m_det[i] = 1'b1;
                    end else if (m_lo[i] == SAMPLES && m_hi[i] == SAMPLES) begin
                        m_phase[i] = 2; m_det[i] = 1'b0;
                    end else if (m_obs_n[i] == TIMEOUT) begin
                        m_phase[i] = 2; m_det[i] = 1'b0; m_tmo[i] = 1'b1;
                    end
                end
                default: begin
                    if (rescan) begin
                        m_phase[i] = 1; m_obs_n[i] = 0;
                        m_lo[i] = 0; m_hi[i] = 0; m_mis[i] = 0; m_tmo[i] = 1'b0;
                    end
                end
            endcase
        end
        cap_q.push_back({ppu_rd_in, ppu_a13_in, ppu_not_a13});
        if (cap_q.size() > 4) void'(cap_q.pop_front());
    endtask

    task automatic check_dut(input int i, input logic hl, input logic dd, input logic tout,
                             input logic nd, input logic [1:0] sd);
        string p;
        logic  nd_exp;
        p = (i == 0) ? "a." : "b.";
        case (force_mode)
            2'b10:   nd_exp = 1'b1;
            2'b01:   nd_exp = 1'b0;
            default: nd_exp = m_det[i];
        endcase
        check({p, "hold_low"},    16'(hl),   16'(m_phase[i] == 0));
        check({p, "detect_done"}, 16'(dd),   16'(m_phase[i] == 2));
        check({p, "timed_out"},   16'(tout), 16'(m_tmo[i]));
        check({p, "new_dendy"},   16'(nd),   16'(nd_exp));
        check({p, "state_dbg"},   16'(sd),   16'(m_phase[i]));
    endtask

    task automatic check_all();
        check_dut(0, hl_a, dd_a, to_a, nd_a, sd_a);
        check_dut(1, hl_b, dd_b, to_b, nd_b, sd_b);
    endtask

    // ---------------- driver tasks ----------------
    // Advance one m2 cycle; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge m2);
        if (rst_n) model_edge();
        else       model_reset();
        @(negedge m2);
        check_all();
    endtask

    task automatic ppu_read(input bit a13, input bit na, input int len, input int gap);
        ppu_rd_in = 1'b0; ppu_a13_in = a13; ppu_not_a13 = na;
        repeat (len) tick();
        ppu_rd_in = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic rescan_pulse();
        rescan = 1'b1;
        tick();
        rescan = 1'b0;
    endtask

    task automatic classic_seq();
        for (int k = 0; k < 3; k++) ppu_read(1'b0, 1'b1, 2, 2);
        for (int k = 0; k < 3; k++) ppu_read(1'b1, 1'b0, 2, 2);
    endtask

    task automatic count_hold(input string tag);
        int hold_ticks;
        hold_ticks = 0;
        while (hl_a && hold_ticks < 40) begin
            tick();
            hold_ticks++;
        end
        check(tag, 16'(hold_ticks), 16'(INIT_CYCLES));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 1'b0; ppu_rd_in = 1'b1; ppu_a13_in = 1'b0; ppu_not_a13 = 1'b1;
        rescan = 1'b0; force_mode = 2'b00;
        model_reset();
        repeat (3) tick();
        check("reset.hold_low", 16'(hl_a), 16'd1);
        check("reset.state",    16'(sd_a), 16'd0);
        check("reset.done",     16'(dd_a), 16'd0);
        check("reset.new",      16'(nd_a), 16'd0);

        // Power-on hold with the bus idle.
        rst_n = 1'b1;
        count_hold("poweron.hold_cycles");
        check("poweron.state", 16'(sd_a), 16'd1);
        check("poweron.done",  16'(dd_a), 16'd0);

        // Classic console.
        classic_seq();
        check("classic.done", 16'(dd_a), 16'd1);
        check("classic.new",  16'(nd_a), 16'd0);
        check("classic.to",   16'(to_a), 16'd0);

        // New famiclone: verdict two rises after the read is first captured.
        rescan_pulse();
        ppu_rd_in = 1'b0; ppu_a13_in = 1'b1; ppu_not_a13 = 1'b1;
        tick();
        check("newfc.cap0.done", 16'(dd_a), 16'd0);
        tick();
        check("newfc.cap1.done", 16'(dd_a), 16'd0);
        ppu_rd_in = 1'b1;
        tick();
        check("newfc.cap2.done", 16'(dd_a), 16'd1);
        check("newfc.cap2.new",  16'(nd_a), 16'd1);
        check("newfc.thr2.done", 16'(dd_b), 16'd0);
        tick();

        // Threshold 2: one mismatch, then consistent reads -> classic.
        classic_seq();
        check("thr2.one_mis.done", 16'(dd_b), 16'd1);
        check("thr2.one_mis.new",  16'(nd_b), 16'd0);

        // Threshold 2: second mismatch before completion -> new famiclone.
        rescan_pulse();
        ppu_read(1'b0, 1'b0, 2, 2);
        ppu_read(1'b0, 1'b1, 2, 2);
        ppu_read(1'b1, 1'b0, 2, 2);
        ppu_read(1'b1, 1'b1, 2, 2);
        ppu_read(1'b0, 1'b1, 2, 2);
        check("thr2.two_mis.done", 16'(dd_b), 16'd1);
        check("thr2.two_mis.new",  16'(nd_b), 16'd1);
        check("thr1.first_mis.new", 16'(nd_a), 16'd1);

        // Timeout with no PPU reads.
        rescan_pulse();
        repeat (TIMEOUT - 1) tick();
        check("timeout.early.done", 16'(dd_a), 16'd0);
        tick();
        check("timeout.done", 16'(dd_a), 16'd1);
        check("timeout.to",   16'(to_a), 16'd1);
        check("timeout.new",  16'(nd_a), 16'd0);
        check("timeout.b.to", 16'(to_b), 16'd1);

        // Rescan after timeout, then a classic console.
        rescan_pulse();
        check("rescan.done_cleared", 16'(dd_a), 16'd0);
        check("rescan.to_cleared",   16'(to_a), 16'd0);
        classic_seq();
        check("rescan.classic.done", 16'(dd_a), 16'd1);
        check("rescan.classic.to",   16'(to_a), 16'd0);
        check("rescan.classic.new",  16'(nd_a), 16'd0);

        // Randomised reads, rescans and overrides against the model.
        for (int it = 0; it < 90; it++) begin
            bit a13r;
            if ($urandom_range(0, 7) == 0) begin
                force_mode = 2'($urandom_range(0, 3));
                #1;
                check_all();
            end
            if ($urandom_range(0, 9) == 0) begin
                rescan_pulse();
            end else begin
                a13r = 1'($urandom_range(0, 1));
                ppu_read(a13r, ($urandom_range(0, 7) == 0) ? a13r : !a13r,
                         $urandom_range(1, 3), $urandom_range(0, 3));
            end
        end
        force_mode = 2'b00;
        #1;
        check_all();

        // Partial counts, then async reset mid-OBSERVE.
        repeat (TIMEOUT + 10) tick();
        rescan_pulse();
        ppu_read(1'b0, 1'b1, 2, 2);
        ppu_read(1'b0, 1'b1, 2, 2);
        ppu_read(1'b1, 1'b0, 2, 2);
        ppu_read(1'b1, 1'b0, 2, 2);
        check("midobs.state", 16'(sd_a), 16'd1);
        ppu_rd_in = 1'b0; ppu_a13_in = 1'b0; ppu_not_a13 = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        ppu_rd_in = 1'b1;
        #1;
        check("async_rst.hold_low",   16'(hl_a), 16'd1);
        check("async_rst.state",      16'(sd_a), 16'd0);
        check("async_rst.done",       16'(dd_a), 16'd0);
        check("async_rst.b.hold_low", 16'(hl_b), 16'd1);
        model_reset();
        check_all();

        // Override acts immediately, even in HOLD.
        force_mode = 2'b10;
        #1;
        check("force_new.a", 16'(nd_a), 16'd1);
        check("force_new.b", 16'(nd_b), 16'd1);
        force_mode = 2'b01;
        #1;
        check("force_classic.a", 16'(nd_a), 16'd0);
        force_mode = 2'b00;
        #1;
        check("force_auto.a", 16'(nd_a), 16'd0);
        @(negedge m2);
        tick();
        tick();
        rst_n = 1'b1;
        count_hold("rst2.hold_cycles");

        // Counts from before reset must be gone: 1+1 reads are not enough.
        ppu_read(1'b0, 1'b1, 2, 2);
        ppu_read(1'b1, 1'b0, 2, 2);
        check("rst2.partial.done",   16'(dd_a), 16'd0);
        check("rst2.partial.b.done", 16'(dd_b), 16'd0);
        ppu_read(1'b0, 1'b1, 2, 2);
        ppu_read(1'b0, 1'b1, 2, 2);
        ppu_read(1'b1, 1'b0, 2, 2);
        ppu_read(1'b1, 1'b0, 2, 2);
        check("rst2.full.done", 16'(dd_a), 16'd1);
        check("rst2.full.new",  16'(nd_a), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
